// File: rtl/ex_mem.sv
// ---------------------------------------------------------------------------
// ex_mem : execute -> memory pipeline register with load hold and ALU bypass
//
// Captures the execute-stage result every cycle. A captured load is held in
// this stage for LOAD_WAIT extra cycles while the synchronous data RAM
// returns its read data. During that time ex_stall tells upstream to freeze.
// flush replaces the stage contents with a bubble. The registered result
// also feeds an ALU-to-ALU bypass (loads are never bypassed from here).
//
// Parameters
//   LOAD_WAIT      extra cycles a load is held (1..7)
//
// Ports
//   clk            clock, all state updates on its rising edge
//   rst_n          synchronous active-low reset
//   flush          discard stage contents (branch/jump redirect)
//   ex_valid       execute stage presents a real instruction
//   ex_alu_res     ALU result / effective address            [31:0]
//   ex_write_data  store data, or pc+1 for jumps              [31:0]
//   ex_is_jump, ex_reg_wrenable, ex_mem_wrenable, ex_mem_to_reg  control bits
//   ex_write_reg   destination register                       [4:0]
//   alu_res, write_data, is_jump, reg_wrenable, mem_wrenable,
//   write_reg, mem_to_reg                registered copies to memory/writeback
//   ex_stall       upstream must hold its outputs this cycle
//   fwd_valid, fwd_reg, fwd_data         ALU-to-ALU bypass source
// ---------------------------------------------------------------------------
module ex_mem #(
   parameter int unsigned LOAD_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        ex_valid,
   input  logic [31:0] ex_alu_res,
   input  logic [31:0] ex_write_data,
   input  logic        ex_is_jump,
   input  logic        ex_reg_wrenable,
   input  logic        ex_mem_wrenable,
   input  logic        ex_mem_to_reg,
   input  logic [4:0]  ex_write_reg,
   output logic [31:0] alu_res,
   output logic [31:0] write_data,
   output logic        is_jump,
   output logic        reg_wrenable,
   output logic        mem_wrenable,
   output logic [4:0]  write_reg,
   output logic        mem_to_reg,
   output logic        ex_stall,
   output logic        fwd_valid,
   output logic [4:0]  fwd_reg,
   output logic [31:0] fwd_data
);

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic [0:0] {
      RUN       = 1'b0,
      LOAD_HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] alu_res;
      logic [DATA_W-1:0] write_data;
      logic              is_jump;
      logic              reg_wrenable;
      logic              mem_wrenable;
      logic [REG_W-1:0]  write_reg;
      logic              mem_to_reg;
   } entry_t;

   localparam entry_t BUBBLE = '0;

   // Turn raw execute-stage fields into a legal stage entry: invalid slots
   // become bubbles, r0 is never written, and an entry flagged as both store
   // and load is treated purely as a store.
   function automatic entry_t sanitize(
      input logic              valid,
      input logic [DATA_W-1:0] alu,
      input logic [DATA_W-1:0] wdata,
      input logic              jump,
      input logic              reg_we,
      input logic              mem_we,
      input logic              m2r,
      input logic [REG_W-1:0]  wreg
   );
      entry_t e;
      e = BUBBLE;
      if (valid) begin
         e.alu_res      = alu;
         e.write_data   = wdata;
         e.is_jump      = jump;
         e.reg_wrenable = reg_we & (wreg != '0);
         e.mem_wrenable = mem_we;
         e.write_reg    = wreg;
         e.mem_to_reg   = m2r & ~mem_we;
      end
      return e;
   endfunction

   // A load needs the RAM read data, so it must be held in this stage.
   function automatic logic is_load(
      input logic valid,
      input logic reg_we,
      input logic mem_we,
      input logic m2r
   );
      return valid & m2r & reg_we & ~mem_we;
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   entry_t      entry_p0, entry_d;
   entry_t      cap;
   logic        cap_load;

   assign cap = sanitize(ex_valid, ex_alu_res, ex_write_data, ex_is_jump,
                         ex_reg_wrenable, ex_mem_wrenable, ex_mem_to_reg,
                         ex_write_reg);
   assign cap_load = is_load(ex_valid, ex_reg_wrenable, ex_mem_wrenable,
                             ex_mem_to_reg);

   // Next-state / next-entry logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      entry_d  = entry_p0;
      ex_stall = 1'b0;
      unique case (state_q)
         RUN: begin
            entry_d = cap;
            if (cap_load) begin
               state_d = LOAD_HOLD;
               cnt_d   = 3'(LOAD_WAIT);
            end
         end
         LOAD_HOLD: begin
            ex_stall = 1'b1;
            // <= 1 rather than == 1 so a corrupted zero count cannot lock up.
            if (cnt_q <= 3'd1) begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      endcase
      if (flush) begin
         entry_d = BUBBLE;
         state_d = RUN;
         cnt_d   = 3'd0;
      end
   end

   // Stage register (p0): control state and the captured entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         cnt_q    <= 3'd0;
         entry_p0 <= BUBBLE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         entry_p0 <= entry_d;
      end
   end

   assign alu_res      = entry_p0.alu_res;
   assign write_data   = entry_p0.write_data;
   assign is_jump      = entry_p0.is_jump;
   assign reg_wrenable = entry_p0.reg_wrenable;
   assign mem_wrenable = entry_p0.mem_wrenable;
   assign write_reg    = entry_p0.write_reg;
   assign mem_to_reg   = entry_p0.mem_to_reg;

   // Jumps write pc+1 (carried in write_data) to the link register.
   assign fwd_valid = entry_p0.reg_wrenable & ~entry_p0.mem_to_reg;
   assign fwd_reg   = entry_p0.write_reg;
   assign fwd_data  = entry_p0.is_jump ? entry_p0.write_data : entry_p0.alu_res;

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;

   localparam int LW = 3;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        ex_valid;
   logic [31:0] ex_alu_res;
   logic [31:0] ex_write_data;
   logic        ex_is_jump;
   logic        ex_reg_wrenable;
   logic        ex_mem_wrenable;
   logic        ex_mem_to_reg;
   logic [4:0]  ex_write_reg;
   logic [31:0] alu_res;
   logic [31:0] write_data;
   logic        is_jump;
   logic        reg_wrenable;
   logic        mem_wrenable;
   logic [4:0]  write_reg;
   logic        mem_to_reg;
   logic        ex_stall;
   logic        fwd_valid;
   logic [4:0]  fwd_reg;
   logic [31:0] fwd_data;

   ex_mem #(.LOAD_WAIT(LW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_res(ex_alu_res), .ex_write_data(ex_write_data),
      .ex_is_jump(ex_is_jump), .ex_reg_wrenable(ex_reg_wrenable),
      .ex_mem_wrenable(ex_mem_wrenable), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_write_reg(ex_write_reg), .alu_res(alu_res), .write_data(write_data),
      .is_jump(is_jump), .reg_wrenable(reg_wrenable),
      .mem_wrenable(mem_wrenable), .write_reg(write_reg),
      .mem_to_reg(mem_to_reg), .ex_stall(ex_stall), .fwd_valid(fwd_valid),
      .fwd_reg(fwd_reg), .fwd_data(fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] write_data;
      logic        is_jump;
      logic        reg_wrenable;
      logic        mem_wrenable;
      logic [4:0]  write_reg;
      logic        mem_to_reg;
      logic        ex_stall;
      logic        fwd_valid;
      logic [4:0]  fwd_reg;
      logic [31:0] fwd_data;
   } obs_t;

   obs_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: what the memory/writeback stage should be looking at,
   // plus how many more cycles the current load keeps the stage busy.
   logic [31:0] m_alu, m_wd;
   logic        m_j, m_rwe, m_mwe, m_m2r;
   logic [4:0]  m_wr;
   int          m_busy = 0;

   task automatic model_edge(input logic r, input logic f, input logic v,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic j, input logic rwe, input logic mwe,
                             input logic m2r, input logic [4:0] wr);
      if (!r || f) begin
         m_alu = 0; m_wd = 0; m_j = 0; m_rwe = 0; m_mwe = 0; m_m2r = 0; m_wr = 0;
         m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy = m_busy - 1;
      end else if (!v) begin
         m_alu = 0; m_wd = 0; m_j = 0; m_rwe = 0; m_mwe = 0; m_m2r = 0; m_wr = 0;
      end else begin
         m_alu = a; m_wd = wd; m_j = j; m_wr = wr; m_mwe = mwe;
         m_rwe = rwe && (wr != 5'd0);
         m_m2r = m2r && !mwe;
         if (m2r && rwe && !mwe) m_busy = LW;
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.alu_res      = m_alu;
      o.write_data   = m_wd;
      o.is_jump      = m_j;
      o.reg_wrenable = m_rwe;
      o.mem_wrenable = m_mwe;
      o.write_reg    = m_wr;
      o.mem_to_reg   = m_m2r;
      o.ex_stall     = (m_busy > 0);
      o.fwd_valid    = m_rwe && !m_m2r;
      o.fwd_reg      = m_wr;
      o.fwd_data     = m_j ? m_wd : m_alu;
      return o;
   endfunction

   // One clock: apply inputs, let the edge happen, record what should follow.
   task automatic step(input logic r, input logic f, input logic v,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic j, input logic rwe, input logic mwe,
                       input logic m2r, input logic [4:0] wr);
      rst_n = r; flush = f; ex_valid = v; ex_alu_res = a; ex_write_data = wd;
      ex_is_jump = j; ex_reg_wrenable = rwe; ex_mem_wrenable = mwe;
      ex_mem_to_reg = m2r; ex_write_reg = wr;
      model_edge(r, f, v, a, wd, j, rwe, mwe, m2r, wr);
      @(posedge clk);
      sb.push_back(model_obs());
      #1;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Monitor: every cycle the stage presents a result, compare it.
   always @(negedge clk) begin
      obs_t exp_o, got_o;
      cyc++;
      if (sb.size() > 0) begin
         exp_o = sb.pop_front();
         got_o = '{alu_res, write_data, is_jump, reg_wrenable, mem_wrenable,
                   write_reg, mem_to_reg, ex_stall, fwd_valid, fwd_reg, fwd_data};
         total++;
         if (got_o !== exp_o) begin
            bad++;
            $display("FAIL stage_out cycle=%0d got alu=%h wd=%h j=%b rwe=%b mwe=%b wr=%0d m2r=%b stall=%b fv=%b fr=%0d fd=%h required alu=%h wd=%h j=%b rwe=%b mwe=%b wr=%0d m2r=%b stall=%b fv=%b fr=%0d fd=%h",
                     cyc, got_o.alu_res, got_o.write_data, got_o.is_jump,
                     got_o.reg_wrenable, got_o.mem_wrenable, got_o.write_reg,
                     got_o.mem_to_reg, got_o.ex_stall, got_o.fwd_valid,
                     got_o.fwd_reg, got_o.fwd_data,
                     exp_o.alu_res, exp_o.write_data, exp_o.is_jump,
                     exp_o.reg_wrenable, exp_o.mem_wrenable, exp_o.write_reg,
                     exp_o.mem_to_reg, exp_o.ex_stall, exp_o.fwd_valid,
                     exp_o.fwd_reg, exp_o.fwd_data);
         end
      end
   end

   initial begin
      // reset, then released with no stall
      step(1'b0, 1'b0, 1'b1, 32'hdead_beef, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      idle();
      // ALU op to r5
      step(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5);
      // load r7 @0x20, then an ALU op held upstream during the stall
      step(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7);
      repeat (LW + 1)
         step(1'b1, 1'b0, 1'b1, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9);
      // jump to r31
      step(1'b1, 1'b0, 1'b1, 32'h99, 32'h41, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31);
      // write to r0, then store flagged mem_to_reg, then bubble
      step(1'b1, 1'b0, 1'b1, 32'h77, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      step(1'b1, 1'b0, 1'b1, 32'h30, 32'hcafe, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4);
      idle();
      // flush during load hold
      step(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8);
      step(1'b1, 1'b1, 1'b1, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
      idle();
      // reset with flush in the middle of a load hold
      step(1'b1, 1'b0, 1'b1, 32'h50, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6);
      step(1'b0, 1'b1, 1'b1, 32'h60, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
      idle();
      idle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, f, v, j, rwe, mwe, m2r;
         logic [4:0] wr;
         r   = ($urandom_range(0, 63) != 0);
         f   = ($urandom_range(0, 15) == 0);
         v   = ($urandom_range(0, 3) != 0);
         j   = ($urandom_range(0, 7) == 0);
         rwe = $urandom_range(0, 1) != 0;
         mwe = ($urandom_range(0, 3) == 0);
         m2r = ($urandom_range(0, 2) == 0);
         wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         step(r, f, v, $urandom, $urandom, j, rwe, mwe, m2r, wr);
      end

      // drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have parameter LOAD_WAIT, default 1, meaning the number of extra cycles a load is held in this stage while the synchronous data RAM returns read data (legal range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port flush  input  1  discard the current stage contents (branch/jump redirect).
REQ-005 SHALL have port ex_valid  input  1  execute stage presents a real instruction.
REQ-006 SHALL have port ex_alu_res  input  32  ALU result or effective address.
REQ-007 SHALL have port ex_write_data  input  32  store data, or pc+1 for jumps.
REQ-008 SHALL have ports ex_is_jump, ex_reg_wrenable, ex_mem_wrenable, ex_mem_to_reg  input  1 each  control bits from decode.
REQ-009 SHALL have port ex_write_reg  input  5  destination register.
REQ-010 SHALL have ports alu_res (32), write_data (32), is_jump (1), reg_wrenable (1), mem_wrenable (1), write_reg (5), mem_to_reg (1)  output  registered copies driving the memory/writeback stage.
REQ-011 SHALL have port ex_stall  output  1  upstream must hold its outputs this cycle.
REQ-012 SHALL have ports fwd_valid (1), fwd_reg (5), fwd_data (32)  output  ALU-to-ALU bypass source.

Function
REQ-013 SHALL implement an FSM with states RUN and LOAD_HOLD plus a 3-bit countdown counter.
REQ-014 In RUN with flush=0, each rising edge SHALL capture all ex_* fields into the output registers (single-cycle latency).
REQ-015 A captured entry with ex_valid=0 SHALL produce a bubble: reg_wrenable, mem_wrenable, is_jump, mem_to_reg all 0; alu_res, write_data, write_reg 0.
REQ-016 A captured entry with ex_write_reg=0 SHALL force reg_wrenable=0 (register 0 is never written); all other fields captured normally.
REQ-017 Capturing a load (ex_valid & ex_mem_to_reg & ex_reg_wrenable) SHALL move the FSM to LOAD_HOLD and load the counter with LOAD_WAIT.
REQ-018 In LOAD_HOLD, output registers SHALL hold their values, ex_stall SHALL be 1, and the counter SHALL decrement each edge; on the edge where the counter is 1 the FSM SHALL return to RUN.
REQ-019 ex_stall SHALL be 0 in RUN; it is a function of state only, never of ex_* inputs.
REQ-020 A load therefore occupies the stage for 1+LOAD_WAIT cycles; the instruction behind it is captured on the first edge after return to RUN.
REQ-021 Stores (ex_mem_wrenable=1) SHALL NOT stall; mem_wrenable SHALL be high for exactly one cycle per store.
REQ-022 A captured entry with both ex_mem_wrenable and ex_mem_to_reg set SHALL be treated as a store only (mem_to_reg cleared, no LOAD_HOLD).
REQ-023 flush=1 (either state) SHALL load a bubble on the next edge, return the FSM to RUN and clear the counter; flush takes priority over capture and hold.
REQ-024 fwd_valid SHALL equal reg_wrenable & ~mem_to_reg; fwd_reg SHALL equal write_reg; fwd_data SHALL equal write_data when is_jump=1, else alu_res (combinational from the output registers).
REQ-025 Loads SHALL never be forwarded from this stage (fwd_valid=0 throughout LOAD_HOLD).
REQ-026 No arithmetic on data fields; all 32-bit fields pass unmodified.

Reset
REQ-027 With rst_n=0 at a rising edge, all outputs SHALL become 0, FSM SHALL be RUN, counter 0; rst_n overrides flush and any LOAD_HOLD in progress.
REQ-028 ex_stall SHALL be 0 in the first cycle after reset is released.

Verification
REQ-029 ALU op: ex_valid=1, ex_alu_res=0x0000_0010, ex_write_reg=5, ex_reg_wrenable=1 -> next cycle alu_res=0x10, reg_wrenable=1, fwd_valid=1, fwd_reg=5, fwd_data=0x10, ex_stall=0.
REQ-030 Load, LOAD_WAIT=1: load to r7 at addr 0x20 then ALU op queued -> ex_stall=1 for exactly 1 cycle, outputs stable at addr 0x20 for 2 cycles, fwd_valid=0, queued op appears in cycle 3.
REQ-031 Jump: ex_is_jump=1, ex_write_data=0x41, ex_alu_res=0x99, write_reg=31 -> fwd_data=0x41, reg_wrenable=1.
REQ-032 Flush during LOAD_HOLD -> next cycle all control outputs 0, ex_stall=0, FSM RUN.
REQ-033 Writes to r0 and store with mem_to_reg=1 -> reg_wrenable=0 / mem_wrenable one-cycle pulse, no stall.
REQ-034 rst_n=0 mid-LOAD_HOLD with flush=1 -> all outputs 0 after the edge, ex_stall=0 after release.
